// File: rtl/ps2_kbd_tx_if.sv
// Scancode handshake bundle: producer offers bytes, the PS/2 frame generator accepts them.
interface ps2_kbd_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: FIFO-buffered scancodes serialised as 11-bit frames
// (start, d0..d7, odd parity, stop) on registered ps2_clk/ps2_data lines.
module ps2_kbd_tx #(
    parameter int unsigned HALF_PERIOD = 16,
    parameter int unsigned GAP_CYCLES  = 32,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clock,
    input  logic                          resetn,
    ps2_kbd_tx_if.slave                   in_bus,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned HW = $clog2(HALF_PERIOD);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned CW = (HW > GW) ? HW : GW;
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full, push, pop;
    logic [7:0]    head;

    state_t        state;
    logic [9:0]    rest;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] cnt;

    assign level           = wptr - rptr;
    assign empty           = (wptr == rptr);
    assign full            = (level == FULL_LVL);
    assign in_bus.in_ready = ~full;
    assign push            = in_bus.in_valid & ~full;
    assign pop             = (state == IDLE) & ~empty;
    assign head            = mem[rptr[AW-1:0]];
    assign busy            = (state != IDLE) | ~empty;

    always_ff @(posedge clock) begin
        if (push)
            mem[wptr[AW-1:0]] <= in_bus.in_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    // The start bit goes straight onto ps2_data at pop time; rest holds the
    // remaining ten bits (d0..d7, parity, stop) and shifts out LSB first.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            rest     <= '0;
            bit_cnt  <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ps2_clk <= 1'b1;
                    if (pop) begin
                        rest     <= {1'b1, ~^head, head};
                        ps2_data <= 1'b0;
                        bit_cnt  <= '0;
                        cnt      <= '0;
                        state    <= HIGH;
                    end else begin
                        ps2_data <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == HP_LAST) begin
                        cnt     <= '0;
                        ps2_clk <= 1'b0;
                        state   <= LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (cnt == HP_LAST) begin
                        cnt     <= '0;
                        ps2_clk <= 1'b1;
                        if (bit_cnt == 4'd10) begin
                            ps2_data <= 1'b1;
                            state    <= GAP;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            ps2_data <= rest[0];
                            rest     <= {1'b0, rest[9:1]};
                            state    <= HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: cycle-level waveform model from frame rules, wire decoder
// against a byte scoreboard, and literal expectations from hand-computed frames.
module tb_ps2_kbd_tx;
    localparam int HP    = 4;
    localparam int GC    = 8;
    localparam int DEPTH = 8;
    localparam int FRAME = 22 * HP;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       ps2_clk, ps2_data, busy;
    logic [3:0] level;

    ps2_kbd_tx_if bus ();

    ps2_kbd_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GC), .FIFO_DEPTH(DEPTH)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .in_bus   (bus),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy),
        .level    (level)
    );

    initial forever #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes queue, frame position k (-1 = idle), wire frame bits.
    logic [7:0]  q[$];
    logic [7:0]  exp_wire[$];
    int          k = -1;
    logic [10:0] cur = '0;
    int          cyc = 0;
    int          t_push = 0;
    int          max_level = 0;
    bit          chk_on = 1'b0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            exp_wire.delete();
            k = -1;
        end else begin
            logic [7:0] b;
            bit acc;
            cyc++;
            acc = bus.in_valid && (q.size() < DEPTH);
            if (k < 0) begin
                if (q.size() > 0) begin
                    b = q.pop_front();
                    cur = {1'b1, ~^b, b, 1'b0};
                    exp_wire.push_back(b);
                    k = 0;
                end
            end else begin
                k++;
                if (k == FRAME + GC)
                    k = -1;
            end
            if (acc) begin
                q.push_back(bus.in_data);
                t_push = cyc;
            end
        end
    end

    always @(negedge clock) begin
        if (resetn && chk_on) begin
            logic ec, ed;
            if (k >= 0 && k < FRAME) begin
                ec = ((k / HP) % 2) == 0;
                ed = cur[k / (2 * HP)];
            end else begin
                ec = 1'b1;
                ed = 1'b1;
            end
            check("ps2_clk", ps2_clk, ec);
            check("ps2_data", ps2_data, ed);
            check("level", level, q.size());
            check("in_ready", bus.in_ready, q.size() < DEPTH);
            check("busy", busy, (k >= 0) || (q.size() > 0));
            if (int'(level) > max_level)
                max_level = int'(level);
        end
    end

    // Wire decoder: samples ps2_data on each ps2_clk fall.
    int          nbits = 0;
    logic [10:0] fbits = '0;
    logic [10:0] last_frame = '0;
    logic [7:0]  dec_log[$];
    logic        par_log[$];
    logic        prev_clk = 1'b1, prev_data = 1'b1, prev_busy = 1'b0;
    int          t_low = 0, t_fall = 0, t_busy_fall = 0;

    always @(negedge clock or negedge resetn) begin
        if (!resetn) begin
            nbits     = 0;
            prev_clk  = 1'b1;
            prev_data = 1'b1;
            prev_busy = 1'b0;
        end else begin
            if (prev_data && !ps2_data && ps2_clk && nbits == 0)
                t_low = cyc;
            if (prev_clk && !ps2_clk) begin
                if (nbits == 0)
                    t_fall = cyc;
                fbits[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    nbits = 0;
                    last_frame = fbits;
                    dec_log.push_back(fbits[8:1]);
                    par_log.push_back(fbits[9]);
                    check("start_bit", fbits[0], 1'b0);
                    check("stop_bit", fbits[10], 1'b1);
                    check("odd_parity", ^fbits[9:1], 1'b1);
                    check("frame_expected", exp_wire.size() > 0, 1'b1);
                    if (exp_wire.size() > 0)
                        check("wire_byte", fbits[8:1], exp_wire.pop_front());
                end
            end
            if (prev_busy && !busy)
                t_busy_fall = cyc;
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
            prev_busy = busy;
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        do begin
            @(posedge clock);
            n++;
        end while (!bus.in_ready && n < 3000);
        check("send_accepted", n < 3000, 1'b1);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((busy || k >= 0) && n < 5000);
        check("idle_reached", n < 5000, 1'b1);
        @(negedge clock);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        #2 resetn = 1'b0;
        #1;
        check("rst_ps2_clk", ps2_clk, 1'b1);
        check("rst_ps2_data", ps2_data, 1'b1);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_level", level, 0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        chk_on = 1'b1;

        // Single byte 0x1C
        send(8'h1C);
        wait_idle();
        check("t1_bits", last_frame, 11'h438);
        check("t1_first_fall", t_fall - t_low, HP);
        check("t1_busy_fall", t_busy_fall - t_push, 22 * HP + GC + 1);

        // Parity corner bytes
        send(8'h00);
        send(8'hFF);
        wait_idle();
        n = dec_log.size();
        check("par00_byte", dec_log[n-2], 8'h00);
        check("par00_parity", par_log[n-2], 1'b1);
        check("parFF_byte", dec_log[n-1], 8'hFF);
        check("parFF_parity", par_log[n-1], 1'b1);

        // Overfill while the first frame is in flight
        max_level = 0;
        for (int i = 0; i < 10; i++)
            send(8'($urandom));
        wait_idle();
        check("full_max_level", max_level, DEPTH);
        check("full_no_lost", exp_wire.size(), 0);

        // Random stream with gaps, wraps pointers
        max_level = 0;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clock);
            send(8'($urandom));
        end
        wait_idle();
        check("wrap_level_bound", max_level <= DEPTH, 1'b1);
        check("wrap_no_lost", exp_wire.size(), 0);

        // Push in the same cycle as the pop from level 1
        send(8'hA5);
        send(8'h3C);
        check("simul_level", level, 1);
        check("simul_data_low", ps2_data, 1'b0);
        wait_idle();
        n = dec_log.size();
        check("simul_first", dec_log[n-2], 8'hA5);
        check("simul_second", dec_log[n-1], 8'h3C);

        // Reset during data bit 4
        send(8'h81);
        send(8'h42);
        n = 0;
        while (nbits != 6 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("reach_bit4", n < 3000, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_ps2_clk", ps2_clk, 1'b1);
        check("midrst_ps2_data", ps2_data, 1'b1);
        check("midrst_level", level, 0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        n = dec_log.size();
        send(8'h5A);
        wait_idle();
        check("post_rst_count", dec_log.size(), n + 1);
        check("post_rst_byte", dec_log[dec_log.size()-1], 8'h5A);
        check("post_rst_bits", last_frame, 11'h6B4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
